ahb3lite_interconnect_master_port: RTL



---
 rtl/ahb3lite_interconnect_master_port.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb3lite_interconnect_master_port.sv
// ahb3lite_interconnect_master_port: per-master front end of the AHB-Lite switch. Decodes the
//   master address to a slave port and forwards the address phase. If that port has not granted
//   this master, it parks the phase in hold registers. It routes the owning port's data-phase
//   response back, and answers unmapped accesses with a two-cycle ERROR.
// Latency: granted transfers pass through combinationally (0 added cycles). Ungranted transfers
//   stall the master for at least one cycle.
// Backpressure: HREADYOUT is low while holding, during ERR1, and whenever the owning slave port
//   stalls.
// Ports: H* = master side, slv* = slave-port side, granted/can_switch = arbitration handshake.
// Option: define AHB3LITE_MP_SEQ2NONSEQ_EN to forward a SEQ transfer as NONSEQ when it was held,
//   or when it targets a slave port other than the current data-phase owner.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MASTER_BITS = 2,
    parameter int SLAVES      = 8,
    parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLAVE_ADDR = '0,
    parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLAVE_MASK = '0
) (
    input  logic                               HCLK,
    input  logic                               HRESET,
    input  logic [MASTER_BITS-1:0]             mst_priority,
    input  logic                               HSEL,
    input  logic [HADDR_SIZE-1:0]              HADDR,
    input  logic [HDATA_SIZE-1:0]              HWDATA,
    output logic [HDATA_SIZE-1:0]              HRDATA,
    input  logic                               HWRITE,
    input  logic [2:0]                         HSIZE,
    input  logic [2:0]                         HBURST,
    input  logic [3:0]                         HPROT,
    input  logic [1:0]                         HTRANS,
    input  logic                               HMASTLOCK,
    input  logic                               HREADY,
    output logic                               HREADYOUT,
    output logic                               HRESP,
    output logic [MASTER_BITS-1:0]             slvpriority,
    output logic [SLAVES-1:0]                  slvHSEL,
    output logic [HADDR_SIZE-1:0]              slvHADDR,
    output logic [HDATA_SIZE-1:0]              slvHWDATA,
    output logic                               slvHWRITE,
    output logic [2:0]                         slvHSIZE,
    output logic [2:0]                         slvHBURST,
    output logic [3:0]                         slvHPROT,
    output logic [1:0]                         slvHTRANS,
    output logic                               slvHMASTLOCK,
    output logic                               slvHREADY,
    input  logic [SLAVES-1:0][HDATA_SIZE-1:0]  slvHRDATA,
    input  logic [SLAVES-1:0]                  slvHREADYOUT,
    input  logic [SLAVES-1:0]                  slvHRESP,
    output logic [SLAVES-1:0]                  can_switch,
    input  logic [SLAVES-1:0]                  granted
);

    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_HOLD, ST_ERR1, ST_ERR2} state_t;

    state_t state, state_nxt;

    logic                  hold_hsel, hold_hwrite, hold_hmastlock;
    logic [HADDR_SIZE-1:0] hold_haddr;
    logic [2:0]            hold_hsize, hold_hburst;
    logic [3:0]            hold_hprot;
    logic [1:0]            hold_htrans;

    logic                  eff_hsel, eff_hwrite, eff_hmastlock;
    logic [HADDR_SIZE-1:0] eff_haddr;
    logic [2:0]            eff_hsize, eff_hburst;
    logic [3:0]            eff_hprot;
    logic [1:0]            eff_htrans;

    logic [SW-1:0]         tgt, data_slave;
    logic                  mapped;
    logic [SLAVES-1:0]     hit;
    logic                  accept, capture, load_ds;

    // While holding, the slave ports see the parked phase rather than the master's next one.
    assign eff_hsel      = (state == ST_HOLD) ? hold_hsel      : HSEL;
    assign eff_haddr     = (state == ST_HOLD) ? hold_haddr     : HADDR;
    assign eff_hwrite    = (state == ST_HOLD) ? hold_hwrite    : HWRITE;
    assign eff_hsize     = (state == ST_HOLD) ? hold_hsize     : HSIZE;
    assign eff_hburst    = (state == ST_HOLD) ? hold_hburst    : HBURST;
    assign eff_hprot     = (state == ST_HOLD) ? hold_hprot     : HPROT;
    assign eff_htrans    = (state == ST_HOLD) ? hold_htrans    : HTRANS;
    assign eff_hmastlock = (state == ST_HOLD) ? hold_hmastlock : HMASTLOCK;

    // Scanning downwards lets the lowest matching index overwrite higher ones.
    always_comb begin
        tgt    = '0;
        mapped = 1'b0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((eff_haddr & SLAVE_MASK[s]) == SLAVE_ADDR[s]) begin
                tgt    = SW'(s);
                mapped = 1'b1;
            end
        end
    end

    always_comb begin
        hit = '0;
        if (mapped) hit[tgt] = 1'b1;
    end

    assign accept = HREADY & HSEL & HTRANS[1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        load_ds   = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state == ST_DATA) begin
                    HREADYOUT = slvHREADYOUT[data_slave];
                    HRESP     = slvHRESP[data_slave];
                    HRDATA    = slvHRDATA[data_slave];
                end else if (state == ST_ERR2) begin
                    HRESP     = 1'b1;
                end
                // A data phase still being stretched by its slave port keeps ownership.
                if (state == ST_DATA && !HREADY) begin
                    state_nxt = ST_DATA;
                end else if (accept) begin
                    if (!mapped) begin
                        state_nxt = ST_ERR1;
                    end else if (granted[tgt]) begin
                        state_nxt = ST_DATA;
                        load_ds   = 1'b1;
                    end else begin
                        state_nxt = ST_HOLD;
                        capture   = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                HREADYOUT = 1'b0;
                if (granted[tgt] && slvHREADYOUT[tgt]) begin
                    state_nxt = ST_DATA;
                    load_ds   = 1'b1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hold_hsel      <= 1'b0;
            hold_haddr     <= '0;
            hold_hwrite    <= 1'b0;
            hold_hsize     <= '0;
            hold_hburst    <= '0;
            hold_hprot     <= '0;
            hold_htrans    <= '0;
            hold_hmastlock <= 1'b0;
        end else if (capture) begin
            hold_hsel      <= HSEL;
            hold_haddr     <= HADDR;
            hold_hwrite    <= HWRITE;
            hold_hsize     <= HSIZE;
            hold_hburst    <= HBURST;
            hold_hprot     <= HPROT;
            hold_htrans    <= HTRANS;
            hold_hmastlock <= HMASTLOCK;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)       data_slave <= '0;
        else if (load_ds) data_slave <= tgt;
    end

`ifdef AHB3LITE_MP_SEQ2NONSEQ_EN
    // A slave port seeing this transfer first has no preceding beat, so SEQ would be illegal there.
    always_comb begin
        slvHTRANS = eff_htrans;
        if (eff_htrans == TRANS_SEQ && (state == ST_HOLD || tgt != data_slave))
            slvHTRANS = TRANS_NONSEQ;
    end
`else
    assign slvHTRANS = eff_htrans;
`endif

    assign slvpriority  = mst_priority;
    assign slvHSEL      = {SLAVES{eff_hsel}} & hit;
    assign slvHADDR     = eff_haddr;
    assign slvHWDATA    = HWDATA;
    assign slvHWRITE    = eff_hwrite;
    assign slvHSIZE     = eff_hsize;
    assign slvHBURST    = eff_hburst;
    assign slvHPROT     = eff_hprot;
    assign slvHMASTLOCK = eff_hmastlock;
    assign slvHREADY    = HREADYOUT;

    // Releasing is only safe at a burst boundary, outside a locked sequence, and when nothing is parked.
    assign can_switch = {SLAVES{~eff_hmastlock
                                & (eff_htrans == TRANS_IDLE || eff_htrans == TRANS_NONSEQ)
                                & (state != ST_HOLD)}};

endmodule
